// File: rtl/board_store_if.sv
// Bus bundle between the user state machine / VGA side and board_store:
// the square-update stream, the read port and the board/capture status.
interface board_store_if;
    logic [10:0]  changePiece;
    logic [2:0]   currentState;
    logic [5:0]   readAddr;
    logic [3:0]   readData;
    logic [255:0] entireBoard;
    logic         captureValid;
    logic [3:0]   capturedPiece;
    logic [3:0]   whiteCaptures;
    logic [3:0]   blackCaptures;
    logic         gameOver;
    logic         winner;

    modport master (
        output changePiece, currentState, readAddr,
        input  readData, entireBoard, captureValid, capturedPiece,
        input  whiteCaptures, blackCaptures, gameOver, winner
    );

    modport slave (
        input  changePiece, currentState, readAddr,
        output readData, entireBoard, captureValid, capturedPiece,
        output whiteCaptures, blackCaptures, gameOver, winner
    );
endinterface

// File: rtl/board_store.sv
// 64-square chess board store: applies single-square change words, tracks
// captures and king captures, and exposes the board plus a registered read port.
module board_store (
    input  logic        clk,
    input  logic        reset,
    board_store_if.slave bus
);

    function automatic logic [3:0] init_piece(input logic [5:0] sq);
        logic [2:0] back;
        case (sq[5:3])
            3'd0:    back = 3'd5;
            3'd1:    back = 3'd4;
            3'd2:    back = 3'd3;
            3'd3:    back = 3'd2;
            3'd4:    back = 3'd1;
            3'd5:    back = 3'd3;
            3'd6:    back = 3'd4;
            3'd7:    back = 3'd5;
            default: back = 3'd0;
        endcase
        case (sq[2:0])
            3'd0:    init_piece = {1'b1, back};
            3'd1:    init_piece = 4'b1110;
            3'd6:    init_piece = 4'b0110;
            3'd7:    init_piece = {1'b0, back};
            default: init_piece = 4'b0000;
        endcase
    endfunction

    function automatic logic [255:0] initial_layout();
        logic [255:0] b;
        b = 256'd0;
        for (int a = 0; a < 64; a++) begin
            b[4*a +: 4] = init_piece(6'(a));
        end
        return b;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

    logic [255:0] board_r;
    logic [3:0]   read_data_r;
    logic         capture_valid_r;
    logic [3:0]   captured_piece_r;
    logic [3:0]   white_captures_r;
    logic [3:0]   black_captures_r;
    logic         game_over_r;
    logic         winner_r;

    logic [5:0]   write_addr_s;
    logic [3:0]   new_piece_s;
    logic [3:0]   old_piece_s;
    logic         start_s;
    logic         accept_s;
    logic         capture_s;

    assign write_addr_s = bus.changePiece[5:0];
    assign new_piece_s  = bus.changePiece[9:6];
    assign old_piece_s  = board_r[{write_addr_s, 2'b00} +: 4];
    assign start_s      = (bus.currentState == 3'b000);

    // Write acceptance and capture detection against the stored square content
    always_comb begin
        accept_s  = 1'b0;
        capture_s = 1'b0;
        if (bus.changePiece[10] && !start_s && !game_over_r) begin
            accept_s  = 1'b1;
            capture_s = (old_piece_s[2:0] != 3'd0) && (new_piece_s[2:0] != 3'd0)
                        && (old_piece_s[3] != new_piece_s[3]);
        end else begin
            accept_s  = 1'b0;
            capture_s = 1'b0;
        end
    end

    // Board, read port and capture bookkeeping; start state reloads the layout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board_r          <= initial_layout();
            read_data_r      <= 4'd0;
            capture_valid_r  <= 1'b0;
            captured_piece_r <= 4'd0;
            white_captures_r <= 4'd0;
            black_captures_r <= 4'd0;
            game_over_r      <= 1'b0;
            winner_r         <= 1'b0;
        end else begin
            read_data_r <= board_r[{bus.readAddr, 2'b00} +: 4];
            if (start_s) begin
                board_r          <= initial_layout();
                capture_valid_r  <= 1'b0;
                captured_piece_r <= 4'd0;
                white_captures_r <= 4'd0;
                black_captures_r <= 4'd0;
                game_over_r      <= 1'b0;
                winner_r         <= 1'b0;
            end else begin
                capture_valid_r <= capture_s;
                if (accept_s) begin
                    board_r[{write_addr_s, 2'b00} +: 4] <= new_piece_s;
                end
                if (capture_s) begin
                    captured_piece_r <= old_piece_s;
                    if (new_piece_s[3]) begin
                        black_captures_r <= sat_inc(black_captures_r);
                    end else begin
                        white_captures_r <= sat_inc(white_captures_r);
                    end
                    if (old_piece_s[2:0] == 3'd1) begin
                        game_over_r <= 1'b1;
                        winner_r    <= new_piece_s[3];
                    end
                end
            end
        end
    end

    assign bus.readData      = read_data_r;
    assign bus.entireBoard   = board_r;
    assign bus.captureValid  = capture_valid_r;
    assign bus.capturedPiece = captured_piece_r;
    assign bus.whiteCaptures = white_captures_r;
    assign bus.blackCaptures = black_captures_r;
    assign bus.gameOver      = game_over_r;
    assign bus.winner        = winner_r;

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed scenarios plus random change
// words, compared every cycle against an array-based board model.
module tb_board_store;

    logic clk;
    logic reset;
    board_store_if bif();

    board_store dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_board [64];
    logic [3:0] m_read;
    logic       m_cv;
    logic [3:0] m_cap;
    int         m_wc;
    int         m_bc;
    logic       m_go;
    logic       m_win;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] start_code(input int a);
        int kinds [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
        int col = a / 8;
        int row = a % 8;
        if (row == 0) return 4'(8 + kinds[col]);
        if (row == 7) return 4'(kinds[col]);
        if (row == 1) return 4'b1110;
        if (row == 6) return 4'b0110;
        return 4'b0000;
    endfunction

    task automatic model_init();
        for (int a = 0; a < 64; a++) m_board[a] = start_code(a);
        m_cv = 1'b0; m_cap = 4'd0; m_wc = 0; m_bc = 0; m_go = 1'b0; m_win = 1'b0;
    endtask

    task automatic model_reset();
        model_init();
        m_read = 4'd0;
    endtask

    task automatic model_step();
        int a;
        logic [3:0] old_p;
        logic [3:0] new_p;
        m_read = m_board[bif.readAddr];
        if (bif.currentState == 3'd0) begin
            model_init();
        end else begin
            m_cv = 1'b0;
            if (bif.changePiece[10] && !m_go) begin
                a     = int'(bif.changePiece[5:0]);
                old_p = m_board[a];
                new_p = bif.changePiece[9:6];
                if (old_p[2:0] != 3'd0 && new_p[2:0] != 3'd0 && old_p[3] != new_p[3]) begin
                    m_cv  = 1'b1;
                    m_cap = old_p;
                    if (new_p[3]) m_bc = (m_bc < 15) ? m_bc + 1 : 15;
                    else          m_wc = (m_wc < 15) ? m_wc + 1 : 15;
                    if (old_p[2:0] == 3'd1) begin
                        m_go  = 1'b1;
                        m_win = new_p[3];
                    end
                end
                m_board[a] = new_p;
            end
        end
    endtask

    task automatic check_all();
        logic [255:0] exp_b;
        exp_b = 256'd0;
        for (int a = 0; a < 64; a++) exp_b[4*a +: 4] = m_board[a];
        chk("entireBoard",   bif.entireBoard,   exp_b);
        chk("readData",      256'(bif.readData),      256'(m_read));
        chk("captureValid",  256'(bif.captureValid),  256'(m_cv));
        chk("capturedPiece", 256'(bif.capturedPiece), 256'(m_cap));
        chk("whiteCaptures", 256'(bif.whiteCaptures), 256'(m_wc));
        chk("blackCaptures", 256'(bif.blackCaptures), 256'(m_bc));
        chk("gameOver",      256'(bif.gameOver),      256'(m_go));
        chk("winner",        256'(bif.winner),        256'(m_win));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [3:0] sq(input int a);
        return bif.entireBoard[4*a +: 4];
    endfunction

    function automatic logic [3:0] rand_piece();
        logic [2:0] kind;
        kind = 3'($urandom_range(0, 6));
        if (kind == 3'd0) return 4'b0000;
        return {1'($urandom_range(0, 1)), kind};
    endfunction

    initial begin
        reset = 1'b0;
        bif.changePiece  = 11'd0;
        bif.currentState = 3'd1;
        bif.readAddr     = 6'd32;
        model_reset();
        #12;
        check_all();
        chk("rst_sq39", 256'(sq(39)), 256'(4'b0001));
        chk("rst_sq0",  256'(sq(0)),  256'(4'b1101));
        chk("rst_sq6",  256'(sq(6)),  256'(4'b0110));
        chk("rst_sq20", 256'(sq(20)), 256'(4'b0000));
        chk("rst_sq7",  256'(sq(7)),  256'(4'b0101));
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk("read_sq32", 256'(bif.readData), 256'(4'b1001));

        bif.changePiece = {1'b1, 4'b0110, 6'd38};
        cycle();
        bif.changePiece = {1'b1, 4'b0000, 6'd39};
        cycle();
        bif.changePiece = 11'd0;
        chk("move_sq38", 256'(sq(38)), 256'(4'b0110));
        chk("move_sq39", 256'(sq(39)), 256'(4'b0000));
        chk("move_cv",   256'(bif.captureValid), 256'(1'b0));

        bif.changePiece = {1'b1, 4'b0110, 6'd1};
        cycle();
        chk("cap_cv",    256'(bif.captureValid),  256'(1'b1));
        chk("cap_piece", 256'(bif.capturedPiece), 256'(4'b1110));
        chk("cap_white", 256'(bif.whiteCaptures), 256'(4'd1));
        cycle();
        chk("cap_hold_cv",    256'(bif.captureValid),  256'(1'b0));
        chk("cap_hold_white", 256'(bif.whiteCaptures), 256'(4'd1));

        bif.currentState = 3'd0;
        bif.changePiece  = {1'b1, 4'b0110, 6'd20};
        cycle();
        bif.currentState = 3'd1;
        bif.changePiece  = 11'd0;
        chk("restart_sq20", 256'(sq(20)), 256'(4'b0000));
        chk("restart_sq39", 256'(sq(39)), 256'(4'b0001));
        chk("restart_white", 256'(bif.whiteCaptures), 256'(4'd0));

        bif.changePiece = {1'b1, 4'b1010, 6'd39};
        cycle();
        chk("king_go",    256'(bif.gameOver),      256'(1'b1));
        chk("king_win",   256'(bif.winner),        256'(1'b1));
        chk("king_black", 256'(bif.blackCaptures), 256'(4'd1));
        bif.changePiece = {1'b1, 4'b0110, 6'd20};
        cycle();
        chk("after_go_sq20", 256'(sq(20)), 256'(4'b0000));

        bif.currentState = 3'd0;
        cycle();
        bif.currentState = 3'd1;
        for (int i = 0; i < 20; i++) begin
            bif.changePiece = {1'b1, 4'b1110, 6'd20};
            cycle();
            bif.changePiece = {1'b1, 4'b0110, 6'd20};
            cycle();
        end
        chk("sat_white", 256'(bif.whiteCaptures), 256'(4'd15));
        chk("sat_black", 256'(bif.blackCaptures), 256'(4'd15));

        bif.changePiece = {1'b1, 4'b0001, 6'd55};
        cycle();
        bif.changePiece = {1'b1, 4'b0000, 6'd39};
        cycle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_sq39", 256'(sq(39)), 256'(4'b0001));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            bif.readAddr = 6'($urandom_range(0, 63));
            bif.currentState = ($urandom_range(0, 59) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if ($urandom_range(0, 4) != 0) begin
                bif.changePiece = {1'($urandom_range(0, 3) != 0), rand_piece(), 6'($urandom_range(0, 63))};
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_store.md
# board_store

Holds the 64-square chess board and writes it from the single-square update stream produced by the user state machine. Decodes each 11-bit change word, detects captures and king captures, keeps per-side capture counts, and exports the full 256-bit board (back to move logic and allowMove checking) plus a registered per-square read port for the VGA renderer. Loads the standard starting layout on reset and whenever the game is in its start state.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- changePiece  in  11  [5:0] square address, [9:6] new content, [10] write enable (level; may stay high on consecutive cycles).
- currentState  in  3  user FSM state; 3'b000 = start game.
- readAddr  in  6  VGA read square address.
- readData  out  4  content of readAddr, registered.
- entireBoard  out  256  square a at bits [4a+3:4a], registered.
- captureValid  out  1  one-cycle pulse: the last accepted write captured a piece.
- capturedPiece  out  4  code of the most recently captured piece; held until the next capture.
- whiteCaptures  out  4  black pieces taken by white, saturating at 15.
- blackCaptures  out  4  white pieces taken by black, saturating at 15.
- gameOver  out  1  sticky; set when a king is captured.
- winner  out  1  color bit of the capturing side (0 white, 1 black); valid while gameOver = 1.

## Operation
- Address map: a = col*8 + row. Col is a[5:3]; row is a[2:0]. Row 0 is the black back rank; row 7 is the white back rank.
- Piece codes: bit 3 is color (0 white, 1 black); [2:0] is 0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn. Empty squares are stored as 4'b0000.
- Initial layout:
  - Back ranks by col 0..7: rook, knight, bishop, queen, king, bishop, knight, rook.
  - Black (1xxx) on row 0; white (0xxx) on row 7.
  - Black pawns (1110) on row 1; white pawns (0110) on row 6.
  - All other squares 0000.
  - Examples: square 39 = 0001, 32 = 1001, 7 = 0101, 0 = 1101, 6 = 0110.
- Init: on reset, or on any clock edge with currentState == 3'b000:
  - load the initial layout;
  - clear both counters, capturedPiece, captureValid, gameOver and winner.
  - Init has priority over any write in the same cycle.
- Write: accepted when changePiece[10] = 1, currentState != 0 and gameOver = 0. The addressed square takes changePiece[9:6]. Writes while gameOver = 1 are ignored.
- Capture: a write is a capture when the old content[2:0] != 0, the new content[2:0] != 0, and old[3] != new[3]. On a capture:
  - captureValid pulses;
  - capturedPiece takes the old content;
  - the counter of the side new[3] increments (saturating at 15).
  - If the old content[2:0] == 1 (king), gameOver is set and winner = new[3].
- Repeated writes of identical data to the same square (enable held high) are not captures. A write of 0000 (vacating a square) is never a capture.
- Only stored data is used for capture detection; no move legality is checked here.

## Timing
- Write at edge N: entireBoard and the counters reflect it from edge N onward (visible in cycle N+1). captureValid is high for cycle N+1 only.
- Read: readData at edge N is board[readAddr] sampled at edge N, before any write at that edge (read-before-write). Latency is 1 cycle.
- One write per cycle. Back-to-back writes to different squares on consecutive cycles must both land (castling issues 3–4 consecutive writes).
- Reset values:
  - entireBoard = initial layout;
  - readData = 0;
  - captureValid = 0, capturedPiece = 0;
  - both counters = 0;
  - gameOver = 0, winner = 0.
- Reset asserted mid-sequence aborts it; the board returns to the initial layout asynchronously.

## Test plan
- Reset release with currentState = 1: entireBoard[159:156] (square 39) = 0001, square 0 = 1101, square 6 = 0110, square 20 = 0000. readAddr = 32 gives readData = 1001 one cycle later.
- Plain move: write {1, 0110, 38} then {1, 0000, 39} on consecutive cycles. Result: square 38 = 0110, square 39 = 0000, no captureValid, counters unchanged.
- Capture: write {1, 0110, 1} (white pawn onto black pawn at square 1). Result: captureValid pulses once, capturedPiece = 1110, whiteCaptures = 1. Holding enable a second cycle gives no second pulse.
- King capture: write {1, 1010, 39}. Result: gameOver = 1, winner = 1, blackCaptures = 1. A following write {1, 0000, 20} is ignored (square 20 unchanged).
- Restart: drive currentState = 0 for one cycle with changePiece[10] = 1. Result: initial layout restored, gameOver = 0, counters = 0, and the write is ignored.
- Async reset mid-castle: assert reset between the king write and the rook write. Result: the board immediately equals the initial layout and all outputs return to their reset values.
